// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM encoding and helpers shared by the HI/LO multiply/divide unit
package mdu_pkg;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? -x : x;
    endfunction
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: iterative radix-2 restoring unsigned divider, one quotient bit per cycle
// ports: clk, rst (sync, active-high), start loads dividend/divisor;
//        quotient/remainder are final once valid is high (held until next start)
module mdu_div_core #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        valid
);
    logic [31:0] rem, quo, dvs;
    logic [5:0]  cnt;
    logic [32:0] sh;
    logic        ge;

    // 33-bit partial remainder: previous remainder with the next dividend bit shifted in
    always_comb begin
        sh = {rem, quo[31]};
        ge = sh >= {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (start) begin
            rem   <= '0;
            quo   <= dividend;
            dvs   <= divisor;
            cnt   <= 6'(ITERS);
            valid <= 1'b0;
        end else if (cnt != 0) begin
            rem   <= ge ? 32'(sh - {1'b0, dvs}) : sh[31:0];
            quo   <= {quo[30:0], ge};
            cnt   <= cnt - 6'd1;
            valid <= cnt == 6'd1;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: multi-cycle multiply/divide unit owning the architectural HI/LO registers
// ports: clk, rst (sync, active-high); start qualifies op/a/b; flush cancels in-flight work;
//        busy stalls consumers; done pulses the cycle new mul/div results appear on hi/lo
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int MUL_LAT   = 2,
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    state_t      state, state_n;
    logic [5:0]  cnt;
    logic [31:0] ma, mb, div_q, div_r, q_fix, r_fix, dvd, dvs;
    logic        msgn, neg_q, neg_r, div_valid;
    logic        accept, is_mul, is_div, mul_wr, div_wr, div_start;
    logic signed [63:0] ps;
    logic [63:0] pu, prod;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !accept ? IDLE : is_mul ? MUL : is_div ? DIV : IDLE;
            MUL:     state_n = cnt == 0 ? IDLE : MUL;
            DIV:     state_n = cnt == 0 ? FIX : DIV;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_comb begin
        is_mul    = op == OP_MULT || op == OP_MULTU;
        is_div    = op == OP_DIV || op == OP_DIVU;
        accept    = state == IDLE && start && !flush;
        div_start = accept && is_div;
        mul_wr    = state == MUL && cnt == 0 && !flush;
        div_wr    = state == FIX && div_valid && !flush;
        busy      = state != IDLE;
    end

    // Divider works on magnitudes; signs are reapplied in FIX.
    always_comb begin
        dvd   = op == OP_DIV ? abs32(a) : a;
        dvs   = op == OP_DIV ? abs32(b) : b;
        q_fix = neg_q ? -div_q : div_q;
        r_fix = neg_r ? -div_r : div_r;
        ps    = $signed(ma) * $signed(mb);
        pu    = {32'b0, ma} * {32'b0, mb};
        prod  = msgn ? ps : pu;
    end

    mdu_div_core #(.ITERS(DIV_ITERS)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (dvd),
        .divisor   (dvs),
        .quotient  (div_q),
        .remainder (div_r),
        .valid     (div_valid)
    );

    // DIV counter spans DIV_ITERS cycles so FIX lands on the divider's final cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            cnt   <= '0;
            ma    <= '0;
            mb    <= '0;
            msgn  <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            done <= mul_wr || div_wr;
            if (accept) begin
                ma    <= a;
                mb    <= b;
                msgn  <= op == OP_MULT;
                neg_q <= op == OP_DIV && (a[31] ^ b[31]);
                neg_r <= op == OP_DIV && a[31];
                cnt   <= is_mul ? 6'(MUL_LAT - 1) : 6'(DIV_ITERS - 1);
                if (op == OP_MTHI) hi <= a;
                if (op == OP_MTLO) lo <= a;
            end else if ((state == MUL || state == DIV) && cnt != 0) begin
                cnt <= cnt - 6'd1;
            end
            if (mul_wr) {hi, lo} <= prod;
            if (div_wr) begin
                hi <= r_fix;
                lo <= q_fix;
            end
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed and randomized checks of hilo_mdu against an arithmetic reference model
module tb_hilo_mdu;
    import mdu_pkg::*;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst, start, flush, busy, done;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [31:0] hi_m = '0, lo_m = '0;
    int          checks = 0, errors = 0;

    hilo_mdu #(.MUL_LAT(MUL_LAT), .DIV_ITERS(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] h, input logic [31:0] l);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = {h, l};
        case (o)
            OP_MULT:  res = 64'(sx * sy);
            OP_MULTU: res = {32'b0, x} * {32'b0, y};
            OP_DIV: begin
                if (y == 0) res = {x, x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU:  res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            OP_MTHI:  res = {x, l};
            OP_MTLO:  res = {h, x};
            default:  res = {h, l};
        endcase
        return res;
    endfunction

    function automatic int lat(input logic [2:0] o);
        return o <= OP_MULTU ? MUL_LAT : o <= OP_DIVU ? DIV_LAT : 0;
    endfunction

    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int inj, input string tag);
        int n = 0, spur = 0;
        logic [63:0] e;
        e = model(o, x, y, hi_m, lo_m);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy && n < 100) begin
            if (done) spur++;
            if (n == inj) begin
                start = 1'b1; op = OP_MULT; a = $urandom; b = $urandom;
            end else start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'(lat(o)));
        chk({tag, " done"}, {63'b0, done}, {63'b0, lat(o) > 0});
        chk({tag, " hilo"}, {hi, lo}, e);
        chk({tag, " early done"}, 64'(spur), 64'd0);
        hi_m = e[63:32];
        lo_m = e[31:0];
        @(negedge clk);
        chk({tag, " done pulse"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset hilo", {hi, lo}, 64'd0);
        chk("reset busy/done", {62'b0, busy, done}, 64'd0);

        run(OP_MTHI, 32'h1234_5678, 32'h0, -1, "mthi");
        chk("mthi hi", {32'b0, hi}, 64'h1234_5678);
        run(OP_MTLO, 32'h9ABC_DEF0, 32'h0, -1, "mtlo");
        chk("mtlo lo", {32'b0, lo}, 64'h9ABC_DEF0);
        run(OP_MULT, 32'hFFFF_FFFE, 32'd3, -1, "mult");
        chk("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run(OP_MULTU, 32'hFFFF_FFFE, 32'd3, -1, "multu");
        chk("multu const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        run(OP_DIV, -32'sd7, 32'd2, -1, "div");
        chk("div const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run(OP_DIVU, 32'd100, 32'd7, -1, "divu");
        chk("divu const", {hi, lo}, {32'd2, 32'd14});
        run(OP_DIVU, 32'd5, 32'd0, -1, "divu by 0");
        chk("divu by 0 const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div ovf");
        chk("div ovf const", {hi, lo}, {32'd0, 32'h8000_0000});
        run(OP_DIV, -32'sd9, 32'd0, -1, "div neg by 0");
        chk("div neg by 0 const", {hi, lo}, {-32'sd9, 32'd1});

        run(OP_MTHI, 32'hAA, 32'h0, -1, "pre hi");
        run(OP_MTLO, 32'hBB, 32'h0, -1, "pre lo");
        op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush busy before", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy after", {63'b0, busy}, 64'd0);
        chk("flush no done", {63'b0, done}, 64'd0);
        @(negedge clk);
        chk("flush no done later", {63'b0, done}, 64'd0);
        chk("flush hilo kept", {hi, lo}, {32'hAA, 32'hBB});
        run(OP_MULT, 32'h0001_0003, 32'hFFFF_0007, -1, "mult after flush");

        flush = 1'b1; start = 1'b1; op = OP_MTLO; a = 32'hDEAD_BEEF;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush beats start", {hi, lo}, {hi_m, lo_m});

        run(OP_DIV, 32'd1000, 32'hFFFF_FFF9, 5, "div ignore start");

        op = OP_DIV; a = 32'd77; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst hilo", {hi, lo}, 64'd0);
        chk("mid rst busy/done", {62'b0, busy, done}, 64'd0);
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        chk("mid rst no done", {63'b0, done}, 64'd0);

        for (int i = 0; i < 30; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            int          k;
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            k = $urandom_range(0, 9);
            if (k == 0) y = 32'h0;
            if (k == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (k == 2) y = 32'($urandom_range(1, 15));
            run(o, x, y, -1, $sformatf("rand%0d op%0d", i, o));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
